// File: rtl/bus_pkg.sv
// Shared definitions for the CPU-to-peripheral response multiplexer:
// FSM state encoding, peripheral slot numbering and error-response defaults.
package bus_pkg;

    localparam int DATA_W          = 32;
    localparam int NSLAVES_DEFAULT = 11;
    localparam int TMO_W           = 8;

    localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } bus_state_t;

    // Slot numbers double as priority: a lower index wins on overlapping decodes.
    typedef enum int {
        SLV_SRAM       = 0,
        SLV_SDRAM      = 1,
        SLV_AUDIO_RAM  = 2,
        SLV_VIDEO_RAM  = 3,
        SLV_AUDIO_CTRL = 4,
        SLV_VIDEO_CTRL = 5,
        SLV_SPI        = 6,
        SLV_TIMERS     = 7,
        SLV_UART_TX    = 8,
        SLV_UART_RX    = 9,
        SLV_GPIO       = 10
    } slave_idx_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts WAIT cycles for the response mux; expired flags the LIMIT-th cycle
// of a wait so the mux can force an error response on that edge.
module bus_timeout_counter
    import bus_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TMO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + TMO_W'(1);
        end
    end

    assign expired = (count == TMO_W'(LIMIT - 1));

endmodule

// File: rtl/bus_response_mux.sv
// Arbitrates one CPU access across NSLAVES peripherals and returns the response.
// Optional WAIT-state timeout is built only when BUS_TIMEOUT_EN is defined.
module bus_response_mux
    import bus_pkg::*;
#(
    parameter int                NSLAVES        = NSLAVES_DEFAULT,
    parameter int                TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_valid,
    output logic                        mem_ready,
    output logic [DATA_W-1:0]           mem_rdata,
    input  logic [NSLAVES-1:0]          sel,
    output logic [NSLAVES-1:0]          slv_valid,
    input  logic [NSLAVES-1:0]          slv_ready,
    input  logic [DATA_W*NSLAVES-1:0]   slv_rdata,
    output logic                        bus_err
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("bus_response_mux: TIMEOUT_CYCLES must be within 1..255");
    end

    bus_state_t          state;
    logic [NSLAVES-1:0]  grant;
    logic [NSLAVES-1:0]  first_sel;
    logic                grant_hit;
    logic [DATA_W-1:0]   grant_rdata;
    logic                tmo_expired;

    // Lowest set bit of sel, one-hot; scanning downward lets index 0 win.
    always_comb begin
        first_sel = '0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if (sel[i]) begin
                first_sel    = '0;
                first_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        grant_hit   = 1'b0;
        grant_rdata = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (grant[i] && slv_ready[i]) begin
                grant_hit   = 1'b1;
                grant_rdata = slv_rdata[DATA_W*i +: DATA_W];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    logic tmo_clear;
    logic tmo_enable;

    // Held clear outside WAIT so every wait starts counting from zero.
    assign tmo_clear  = (state != ST_WAIT);
    assign tmo_enable = (state == ST_WAIT);

    bus_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant     <= '0;
            slv_valid <= '0;
            mem_ready <= 1'b0;
            bus_err   <= 1'b0;
            mem_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    mem_ready <= 1'b0;
                    bus_err   <= 1'b0;
                    slv_valid <= '0;
                    if (mem_valid) begin
                        if (sel == '0) begin
                            state     <= ST_RESP;
                            mem_ready <= 1'b1;
                            bus_err   <= 1'b1;
                            mem_rdata <= ERR_RDATA;
                        end else begin
                            state     <= ST_WAIT;
                            grant     <= first_sel;
                            slv_valid <= first_sel;
                        end
                    end
                end

                // A withdrawn request takes precedence over a late slave ready.
                ST_WAIT: begin
                    if (!mem_valid) begin
                        state     <= ST_IDLE;
                        slv_valid <= '0;
                    end else if (grant_hit) begin
                        state     <= ST_RESP;
                        slv_valid <= '0;
                        mem_ready <= 1'b1;
                        mem_rdata <= grant_rdata;
                    end else if (tmo_expired) begin
                        state     <= ST_RESP;
                        slv_valid <= '0;
                        mem_ready <= 1'b1;
                        bus_err   <= 1'b1;
                        mem_rdata <= ERR_RDATA;
                    end
                end

                ST_RESP: begin
                    state     <= ST_IDLE;
                    mem_ready <= 1'b0;
                    bus_err   <= 1'b0;
                end

                default: begin
                    state     <= ST_IDLE;
                    slv_valid <= '0;
                    mem_ready <= 1'b0;
                    bus_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule
